// File: rtl/fifo_pkg.sv
// Shared defaults and derived widths for the programmable synchronous FIFO.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    // Contents are deliberately left out of reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// flush, status pulses and a selectable registered or fall-through read port.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int FWFT       = 0,
    localparam int CNT_W      = cntWidth(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      count,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  wrAck_q, wrAck_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [FIFO_WIDTH-1:0] memRdData;
    logic                  wrAccept;
    logic                  rdAccept;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_level);
    assign almostempty = (count_q <= ae_level);

    // Gating on full/empty makes a simultaneous request degrade to the one that can proceed.
    assign wrAccept = wr_en && !full  && !flush;
    assign rdAccept = rd_en && !empty && !flush;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        wrAck_d     = wrAccept;
        overflow_d  = wr_en && full  && !flush;
        underflow_d = rd_en && empty && !flush;

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (rdAccept) begin
                rdPtr_d   = rdPtr_q + 1'b1;
                dataOut_d = memRdData;
            end
            unique case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            wrAck_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            wrAck_q     <= wrAck_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uMem (
        .clk_i    (clk),
        .wrEn_i   (wrAccept),
        .wrAddr_i (wrPtr_q),
        .wrData_i (data_in),
        .rdAddr_i (rdPtr_q),
        .rdData_o (memRdData)
    );

    // In fall-through mode the register keeps the last popped head so the output stays stable while empty.
    generate
        if (FWFT != 0) begin : gFwft
            assign data_out = empty ? dataOut_q : memRdData;
        end else begin : gRegRead
            assign data_out = dataOut_q;
        end
    endgenerate

    assign count     = count_q;
    assign wr_ack    = wrAck_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have derived constant CNT_W = clog2(FIFO_DEPTH)+1, occupancy width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port data_in, input, FIFO_WIDTH, write data.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port flush, input, 1, synchronous empty command.
REQ-011 SHALL have port af_level, input, CNT_W, almost-full threshold.
REQ-012 SHALL have port ae_level, input, CNT_W, almost-empty threshold.
REQ-013 SHALL have port data_out, output, FIFO_WIDTH, read data.
REQ-014 SHALL have port count, output, CNT_W, current occupancy 0..FIFO_DEPTH.
REQ-015 SHALL have ports wr_ack, overflow, underflow, output, 1 each, registered status pulses.
REQ-016 SHALL have ports full, empty, almostfull, almostempty, output, 1 each, combinational flags from count.

Function
REQ-017 SHALL accept a write when wr_en=1, full=0 and flush=0; data_in is stored at the write pointer, which then increments modulo FIFO_DEPTH.
REQ-018 SHALL accept a read when rd_en=1, empty=0 and flush=0; the read pointer then increments modulo FIFO_DEPTH.
REQ-019 SHALL, on simultaneous accepted read and write, leave count unchanged.
REQ-020 SHALL, when full with wr_en=rd_en=1, perform the read only (count-1).
REQ-021 SHALL, when empty with wr_en=rd_en=1, perform the write only (count+1).
REQ-022 SHALL, with FWFT=0, load data_out on the clock edge of an accepted read, so data is valid the cycle after rd_en; otherwise data_out holds its value.
REQ-023 SHALL, with FWFT=1, drive data_out combinationally with the head entry whenever empty=0; the value is undefined-but-stable (last head) when empty.
REQ-024 SHALL pulse wr_ack high for one cycle after each accepted write.
REQ-025 SHALL pulse overflow high for one cycle after a write rejected by full (excludes flush cycles).
REQ-026 SHALL pulse underflow high for one cycle after a read rejected by empty (excludes flush cycles).
REQ-027 SHALL drive full = (count==FIFO_DEPTH) and empty = (count==0).
REQ-028 SHALL drive almostfull = (count >= af_level) and almostempty = (count <= ae_level); thresholds are sampled live and may change any cycle.
REQ-029 SHALL, on flush=1, zero both pointers and count at the next edge; wr_en/rd_en in that cycle are ignored; wr_ack/overflow/underflow are 0; data_out holds.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, clear pointers, count, data_out, wr_ack, overflow and underflow to 0, giving empty=1 and full=0.
REQ-031 SHALL give rst priority over flush, wr_en and rd_en, including mid-burst.
REQ-032 SHALL not reset storage contents.

Structure
REQ-033 SHALL place default FIFO_WIDTH/FIFO_DEPTH and the CNT_W derivation in shared package fifo_pkg.
REQ-034 SHALL implement storage as sub-module fifo_mem (simple dual-port array, one write port, one asynchronous read port).

Verification
REQ-035 Reset, then write 8 words 0x0001..0x0008 (depth 8) -> wr_ack on each, count=8, full=1, almostfull=1 with af_level=6.
REQ-036 Full, wr_en=1 with 0xBEEF -> overflow=1 next cycle, count stays 8; then 8 reads return 0x0001..0x0008 in order.
REQ-037 Empty, rd_en=1 -> underflow=1 next cycle, count=0; with FWFT=1 a single write of 0x00AA shows data_out=0x00AA the following cycle without rd_en.
REQ-038 Count=4, wr_en=rd_en=1 for 20 cycles -> count stays 4 and the pointers wrap with data order preserved.
REQ-039 Count=5, flush=1 with wr_en=1 -> count=0, empty=1, wr_ack=0; rst=1 asserted together with flush -> all outputs at reset values.
